// File: rtl/mcpu_cu_ws.sv
// Multicycle MIPS control unit: Moore sequencer whose memory-state strobes
// are gated by the memory handshake. It also has a stall watchdog, an
// illegal-opcode trap and a per-instruction retire pulse.
module mcpu_cu_ws #(
  parameter bit MEM_WAIT        = 1'b1,
  parameter int MAX_WAIT        = 15,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       mem_rdy,
  output logic       pcw,
  output logic       pcwc,
  output logic       brne,
  output logic       iord,
  output logic       mr,
  output logic       mw,
  output logic       irw,
  output logic       regw,
  output logic [1:0] mtor,
  output logic [1:0] rdst,
  output logic       alusela,
  output logic [1:0] aluselb,
  output logic [1:0] aluop,
  output logic       tw,
  output logic [1:0] pcs,
  output logic       instr_done,
  output logic       ill_op,
  output logic       mem_err
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam bit WD_EN = MEM_WAIT && (MAX_WAIT > 0);
  localparam int CW    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  // The watchdog fires on the MAX_WAIT-th consecutive stalled cycle, i.e. when
  // the count of earlier stalled cycles equals MAX_WAIT-1.
  localparam int              LIM_I = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;
  localparam logic [CW-1:0]   LIMIT = LIM_I[CW-1:0];

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_WB, S_MEMWR, S_RX, S_RWB,
    S_BR, S_JMP, S_JAL, S_JR, S_AEX, S_AWB, S_TRAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          rdy, wd_st, timeout, legal, set_ill;

  assign rdy     = MEM_WAIT ? mem_rdy : 1'b1;
  assign wd_st   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout = WD_EN && wd_st && !rdy && (cnt_q == LIMIT);
  assign legal   = op inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW};
  assign set_ill = TRAP_ON_ILLEGAL && (state_q == S_DECODE) && !legal;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Stall counter: counts consecutive stalled cycles, clears on leaving the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt_q <= '0;
    else if (WD_EN && wd_st && !rdy && !timeout) cnt_q <= cnt_q + 1'b1;
    else                                       cnt_q <= '0;
  end

  // Sticky fault flags, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ill_op  <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      if (set_ill) ill_op  <= 1'b1;
      if (timeout) mem_err <= 1'b1;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d    = state_q;
    pcw        = 1'b0;
    pcwc       = 1'b0;
    brne       = 1'b0;
    iord       = 1'b0;
    mr         = 1'b0;
    mw         = 1'b0;
    irw        = 1'b0;
    regw       = 1'b0;
    mtor       = 2'b00;
    rdst       = 2'b00;
    alusela    = 1'b0;
    aluselb    = 2'b00;
    aluop      = 2'b00;
    tw         = 1'b0;
    pcs        = 2'b00;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mr      = 1'b1;
        aluselb = 2'b01;
        irw     = rdy;
        pcw     = rdy;
        if (rdy)          state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        aluselb = 2'b11;
        tw      = 1'b1;
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           state_d = (func == FN_JR) ? S_JR : S_RX;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J:           state_d = S_JMP;
          OP_JAL:         state_d = S_JAL;
          OP_ADDI:        state_d = S_AEX;
          default: begin
            if (TRAP_ON_ILLEGAL) state_d = S_TRAP;
            else begin
              state_d    = S_FETCH;
              instr_done = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alusela = 1'b1;
        aluselb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mr   = 1'b1;
        iord = 1'b1;
        if (rdy)          state_d = S_WB;
        else if (timeout) state_d = S_TRAP;
      end
      S_WB: begin
        regw       = 1'b1;
        mtor       = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        // The write strobe is withheld in the cycle the watchdog fires.
        mw   = !timeout;
        iord = 1'b1;
        if (rdy) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (timeout) state_d = S_TRAP;
      end
      S_RX: begin
        alusela = 1'b1;
        aluop   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        regw       = 1'b1;
        rdst       = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BR: begin
        alusela    = 1'b1;
        aluop      = 2'b01;
        pcwc       = 1'b1;
        pcs        = 2'b01;
        brne       = (op == OP_BNE);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JMP: begin
        pcw        = 1'b1;
        pcs        = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC (already PC+4) is written to $31 on the same edge the PC jumps.
        pcw        = 1'b1;
        pcs        = 2'b10;
        regw       = 1'b1;
        rdst       = 2'b10;
        mtor       = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        pcw        = 1'b1;
        pcs        = 2'b11;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_AEX: begin
        alusela = 1'b1;
        aluselb = 2'b10;
        state_d = S_AWB;
      end
      S_AWB: begin
        regw       = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_mcpu_cu_ws.sv
// Bench for mcpu_cu_ws: instruction-level reference model drives random and
// directed instruction streams with random memory stalls into two instances
// (default parameters, and no-wait / illegal-as-NOP).
module tb_mcpu_cu_ws;

  localparam int MAXW = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic       mem_rdy = 1'b0;

  logic pcw_a, pcwc_a, brne_a, iord_a, mr_a, mw_a, irw_a, regw_a, alusela_a, tw_a;
  logic instr_done_a, ill_op_a, mem_err_a;
  logic [1:0] mtor_a, rdst_a, aluselb_a, aluop_a, pcs_a;
  logic pcw_b, pcwc_b, brne_b, iord_b, mr_b, mw_b, irw_b, regw_b, alusela_b, tw_b;
  logic instr_done_b, ill_op_b, mem_err_b;
  logic [1:0] mtor_b, rdst_b, aluselb_b, aluop_b, pcs_b;

  mcpu_cu_ws dut_a (
    .clk(clk), .rst(rst), .op(op), .func(func), .mem_rdy(mem_rdy),
    .pcw(pcw_a), .pcwc(pcwc_a), .brne(brne_a), .iord(iord_a), .mr(mr_a), .mw(mw_a),
    .irw(irw_a), .regw(regw_a), .mtor(mtor_a), .rdst(rdst_a), .alusela(alusela_a),
    .aluselb(aluselb_a), .aluop(aluop_a), .tw(tw_a), .pcs(pcs_a),
    .instr_done(instr_done_a), .ill_op(ill_op_a), .mem_err(mem_err_a)
  );

  mcpu_cu_ws #(.MEM_WAIT(1'b0), .MAX_WAIT(MAXW), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .op(op), .func(func), .mem_rdy(mem_rdy),
    .pcw(pcw_b), .pcwc(pcwc_b), .brne(brne_b), .iord(iord_b), .mr(mr_b), .mw(mw_b),
    .irw(irw_b), .regw(regw_b), .mtor(mtor_b), .rdst(rdst_b), .alusela(alusela_b),
    .aluselb(aluselb_b), .aluop(aluop_b), .tw(tw_b), .pcs(pcs_b),
    .instr_done(instr_done_b), .ill_op(ill_op_b), .mem_err(mem_err_b)
  );

  always #5 clk = ~clk;

  logic [22:0] o_a, o_b;
  assign o_a = {pcw_a, pcwc_a, brne_a, iord_a, mr_a, mw_a, irw_a, regw_a, mtor_a, rdst_a,
                alusela_a, aluselb_a, aluop_a, tw_a, pcs_a, instr_done_a, ill_op_a, mem_err_a};
  assign o_b = {pcw_b, pcwc_b, brne_b, iord_b, mr_b, mw_b, irw_b, regw_b, mtor_b, rdst_b,
                alusela_b, aluselb_b, aluop_b, tw_b, pcs_b, instr_done_b, ill_op_b, mem_err_b};

  int n_run = 0, n_fail = 0;
  bit use_b = 1'b0;         // which instance the model is tracking
  bit fl_ill = 1'b0, fl_mem = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s op=%b func=%b: got %h expected %h", tag, op, func, got, exp);
    end
  endtask

  function automatic logic [22:0] cur();
    return use_b ? o_b : o_a;
  endfunction

  // Instruction phases as the ISA sequencing describes them
  typedef enum {P_F, P_D, P_MA, P_MR, P_WB, P_MW, P_RX, P_RWB, P_BR, P_J, P_JAL, P_JR,
                P_AEX, P_AWB, P_T} ph_t;

  // Expected control word for one cycle of a phase
  function automatic logic [22:0] ev(ph_t ph, bit rdy, bit to, bit bne, bit nop_done);
    logic pc_w = 0, pc_wc = 0, bn = 0, io = 0, rd = 0, wr = 0, ir_w = 0, rg = 0, sa = 0, t = 0, dn = 0;
    logic [1:0] mt = 0, rs = 0, sb = 0, ao = 0, ps = 0;
    case (ph)
      P_F:   begin rd = 1; sb = 1; ir_w = rdy; pc_w = rdy; end
      P_D:   begin sb = 3; t = 1; dn = nop_done; end
      P_MA:  begin sa = 1; sb = 2; end
      P_MR:  begin rd = 1; io = 1; end
      P_WB:  begin rg = 1; mt = 1; dn = 1; end
      P_MW:  begin wr = !to; io = 1; dn = rdy; end
      P_RX:  begin sa = 1; ao = 2; end
      P_RWB: begin rg = 1; rs = 1; dn = 1; end
      P_BR:  begin sa = 1; ao = 1; pc_wc = 1; ps = 1; bn = bne; dn = 1; end
      P_J:   begin pc_w = 1; ps = 2; dn = 1; end
      P_JAL: begin pc_w = 1; ps = 2; rg = 1; rs = 2; mt = 2; dn = 1; end
      P_JR:  begin pc_w = 1; ps = 3; dn = 1; end
      P_AEX: begin sa = 1; sb = 2; end
      P_AWB: begin rg = 1; dn = 1; end
      default: ;
    endcase
    return {pc_w, pc_wc, bn, io, rd, wr, ir_w, rg, mt, rs, sa, sb, ao, t, ps, dn, fl_ill, fl_mem};
  endfunction

  ph_t plan[$];

  function automatic bit is_legal(logic [5:0] o);
    return o inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2b};
  endfunction

  task automatic build_plan(input logic [5:0] o, input logic [5:0] f);
    plan = '{P_F, P_D};
    case (o)
      6'h23: begin plan.push_back(P_MA); plan.push_back(P_MR); plan.push_back(P_WB); end
      6'h2b: begin plan.push_back(P_MA); plan.push_back(P_MW); end
      6'h00: if (f == 6'h08) plan.push_back(P_JR);
             else begin plan.push_back(P_RX); plan.push_back(P_RWB); end
      6'h04, 6'h05: plan.push_back(P_BR);
      6'h02: plan.push_back(P_J);
      6'h03: plan.push_back(P_JAL);
      6'h08: begin plan.push_back(P_AEX); plan.push_back(P_AWB); end
      default: ;
    endcase
  endtask

  // Called just after a negedge with the DUT in FETCH; returns just after a
  // negedge. stall_* = cycles with mem_rdy low before it rises (large = never).
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int stall_f,
                           input int stall_m, output bit trapped);
    bit memwait = !use_b;
    bit ill = !is_legal(o);
    trapped = 0;
    op = o; func = f;
    build_plan(o, f);
    foreach (plan[i]) begin
      if (memwait && plan[i] inside {P_F, P_MR, P_MW}) begin
        int st = (plan[i] == P_F) ? stall_f : stall_m;
        for (int k = 0; k < MAXW; k++) begin
          bit rdy = (k == st);
          bit to  = !rdy && (k == MAXW - 1);
          mem_rdy = rdy;
          #1 chk($sformatf("%s cyc%0d", plan[i].name(), k), cur(), ev(plan[i], rdy, to, 0, 0));
          @(negedge clk);
          if (to) begin fl_mem = 1; trapped = 1; return; end
          if (rdy) break;
        end
      end else begin
        mem_rdy = 1'($urandom);
        #1 chk(plan[i].name(), cur(),
               ev(plan[i], 1'b1, 1'b0, o == 6'h05, plan[i] == P_D && ill && use_b));
        @(negedge clk);
        if (plan[i] == P_D && ill && !use_b) begin fl_ill = 1; trapped = 1; return; end
      end
    end
  endtask

  task automatic check_trap(input int n);
    repeat (n) begin
      mem_rdy = 1'($urandom);
      #1 chk("TRAP", cur(), ev(P_T, 0, 0, 0, 0));
      @(negedge clk);
    end
  endtask

  // Reset pulse held across one rising edge; checks the in-reset outputs.
  task automatic do_reset();
    rst = 0; mem_rdy = 0;
    fl_ill = 0; fl_mem = 0;
    #1 chk("reset", cur(), ev(P_F, use_b, 0, 0, 0));
    @(negedge clk);
    rst = 1;
  endtask

  logic [5:0] legal_ops [8] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08};

  task automatic random_instr();
    logic [5:0] o, f;
    int sf, sm, r;
    bit tr;
    o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
    f = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
    r = $urandom_range(0, 39);
    sf = (r == 0) ? 100 : (r == 1) ? MAXW - 1 : $urandom_range(0, 3);
    r = $urandom_range(0, 39);
    sm = (r == 0) ? 100 : (r == 1) ? MAXW - 1 : $urandom_range(0, 3);
    run_instr(o, f, sf, sm, tr);
    if (tr) begin
      check_trap(2);
      do_reset();
    end
  endtask

  initial begin
    bit tr;
    @(negedge clk);
    do_reset();

    // Directed sequencing on the default instance
    run_instr(6'h23, 6'h00, 0, 0, tr);   // LW, 5 cycles
    run_instr(6'h2b, 6'h00, 0, 3, tr);   // SW, 3-cycle memory stall
    run_instr(6'h05, 6'h00, 0, 0, tr);   // BNE
    run_instr(6'h04, 6'h00, 2, 0, tr);   // BEQ with fetch stall
    run_instr(6'h03, 6'h00, 0, 0, tr);   // JAL
    run_instr(6'h00, 6'h08, 0, 0, tr);   // JR
    run_instr(6'h00, 6'h20, 0, 0, tr);   // R-type add
    run_instr(6'h02, 6'h00, 0, 0, tr);   // J
    run_instr(6'h08, 6'h00, 0, 0, tr);   // ADDI

    // Watchdog boundary: rdy on the 15th stalled cycle completes normally
    run_instr(6'h23, 6'h00, MAXW - 1, MAXW - 1, tr);
    chk("no_trap_at_boundary", 32'(tr), 32'd0);
    // Fetch never ready -> TRAP with mem_err, no IR/PC write
    run_instr(6'h23, 6'h00, 100, 0, tr);
    chk("fetch_timeout", 32'(tr), 32'd1);
    check_trap(3);
    do_reset();
    // Store never ready -> TRAP, write strobe withheld in the timeout cycle
    run_instr(6'h2b, 6'h00, 0, 100, tr);
    chk("store_timeout", 32'(tr), 32'd1);
    check_trap(2);
    do_reset();

    // Illegal opcode traps and sticks until reset
    run_instr(6'h3f, 6'h00, 0, 0, tr);
    chk("illegal_trap", 32'(tr), 32'd1);
    check_trap(4);
    do_reset();
    run_instr(6'h02, 6'h00, 0, 0, tr);

    // Asynchronous reset in the middle of WB drops regw at once
    op = 6'h23; func = 0; mem_rdy = 1;
    repeat (4) @(negedge clk);
    #1 chk("WB pre-reset", cur(), ev(P_WB, 1, 0, 0, 0));
    #1 rst = 0;
    #1 chk("async reset", cur(), ev(P_F, 1, 0, 0, 0));
    @(negedge clk);
    rst = 1;

    repeat (200) random_instr();

    // No-wait instance with illegal opcodes as NOPs
    use_b = 1;
    do_reset();
    run_instr(6'h3f, 6'h00, 0, 0, tr);
    run_instr(6'h23, 6'h00, 5, 5, tr);
    repeat (100) random_instr();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
